// File: rtl/approx_arith_pkg.sv
// Shared constants and state encoding for the approximate divider.
// Widths match the 8x8 -> 16 approximate multiplier family this divider inverts.
package approx_arith_pkg;

  localparam int DIVIDEND_W = 16;
  localparam int DIVISOR_W  = 8;
  localparam int QUOT_W     = 8;

  localparam logic [QUOT_W-1:0] QUOT_SAT = 8'hFF;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t BUSY = 2'd1;
  localparam state_t DONE = 2'd2;

endpackage

// File: rtl/div_restoring_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// then subtract the divisor if it fits.
module div_restoring_step
  import approx_arith_pkg::*;
(
  input  logic [DIVISOR_W:0]   r,
  input  logic                 bit_in,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W:0]   r_next,
  output logic                 qbit
);

  logic [DIVISOR_W:0] r_shift;
  logic [DIVISOR_W:0] diff;

  // The residue is always below the divisor, so the 9-bit shift never loses a set bit.
  assign r_shift = (r << 1) | {{DIVISOR_W{1'b0}}, bit_in};
  assign diff    = r_shift - {1'b0, divisor};
  assign qbit    = (r_shift >= {1'b0, divisor});
  assign r_next  = qbit ? diff : r_shift;

endmodule

// File: rtl/approx_divider16by8.sv
// Iterative 16/8 restoring divider with optional quotient-LSB truncation.
// Define DIV_EARLY_TERM_EN to finish trivial divisions (x/1, 0/y) in one cycle.
module approx_divider16by8
  import approx_arith_pkg::*;
#(
  parameter int APPROX_LSB = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [QUOT_W-1:0]     quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero,
  output logic                  overflow
);

  localparam int N_STEPS = 8 - APPROX_LSB;
  localparam logic [3:0] LAST_STEP = 4'(N_STEPS - 1);

  state_t               state;
  logic [DIVISOR_W:0]   r_q;
  logic [7:0]           dlo_q;
  logic [DIVISOR_W-1:0] dvs_q;
  logic [QUOT_W-1:0]    qacc_q;
  logic [3:0]           step_q;

  logic [DIVISOR_W:0]   r_next;
  logic                 qbit;
  logic [QUOT_W-1:0]    q_next;
  logic [7:0]           hb;
  logic                 accept;
  logic                 early;

  div_restoring_step u_step (
    .r       (r_q),
    .bit_in  (dlo_q[7]),
    .divisor (dvs_q),
    .r_next  (r_next),
    .qbit    (qbit)
  );

  assign hb        = dividend[15:8];
  assign in_ready  = (state == IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign q_next    = (qacc_q << 1) | {{(QUOT_W-1){1'b0}}, qbit};

`ifdef DIV_EARLY_TERM_EN
  assign early = (dividend == '0) || ((divisor == 8'd1) && (hb == 8'd0));
`else
  assign early = 1'b0;
`endif

  // NOTE: all state, including the datapath registers, uses non-blocking
  // assignments and a synchronous reset so an aborted division leaves nothing behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      r_q         <= '0;
      dlo_q       <= '0;
      dvs_q       <= '0;
      qacc_q      <= '0;
      step_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (divisor == '0) begin
              quotient    <= QUOT_SAT;
              remainder   <= dividend[7:0];
              div_by_zero <= 1'b1;
              overflow    <= 1'b0;
              state       <= DONE;
            end else if (hb >= divisor) begin
              quotient    <= QUOT_SAT;
              remainder   <= dividend[7:0];
              div_by_zero <= 1'b0;
              overflow    <= 1'b1;
              state       <= DONE;
            end else if (early) begin
              // x/1 with a zero high byte, or 0/y: the low byte is the exact quotient.
              quotient    <= dividend[7:0];
              remainder   <= '0;
              div_by_zero <= 1'b0;
              overflow    <= 1'b0;
              state       <= DONE;
            end else begin
              r_q    <= {1'b0, hb};
              dlo_q  <= dividend[7:0];
              dvs_q  <= divisor;
              qacc_q <= '0;
              step_q <= '0;
              state  <= BUSY;
            end
          end
        end
        BUSY: begin
          r_q    <= r_next;
          dlo_q  <= dlo_q << 1;
          qacc_q <= q_next;
          step_q <= step_q + 4'd1;
          if (step_q == LAST_STEP) begin
            quotient    <= q_next << APPROX_LSB;
            remainder   <= (APPROX_LSB == 0) ? r_next[DIVISOR_W-1:0] : '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            state       <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_approx_divider16by8.sv
// Scoreboard bench: two divider instances (exact and APPROX_LSB=2) share stimulus;
// expectations are queued on accept and popped by per-instance monitors.
module tb_approx_divider16by8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;

  logic       a_in_ready, a_out_valid, a_dz, a_ov;
  logic [7:0] a_q, a_r;
  logic       b_in_ready, b_out_valid, b_dz, b_ov;
  logic [7:0] b_q, b_r;

  always #5 clk = ~clk;

  approx_divider16by8 dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(a_out_valid),
    .out_ready(out_ready), .quotient(a_q), .remainder(a_r),
    .div_by_zero(a_dz), .overflow(a_ov)
  );

  approx_divider16by8 #(.APPROX_LSB(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(b_out_valid),
    .out_ready(out_ready), .quotient(b_q), .remainder(b_r),
    .div_by_zero(b_dz), .overflow(b_ov)
  );

`ifdef DIV_EARLY_TERM_EN
  localparam int         ET_LAT_A = 1;
  localparam int         ET_LAT_B = 1;
  localparam logic [7:0] ET55_B   = 8'h55;
`else
  localparam int         ET_LAT_A = 9;
  localparam int         ET_LAT_B = 7;
  localparam logic [7:0] ET55_B   = 8'h54;
`endif

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    logic       ov;
    int         lat;
    int         acc;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_b[$];
  exp_t cur_a, cur_b;
  logic prev_a = 1'b0;
  logic prev_b = 1'b0;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor for the exact instance; also verifies outputs stay stable while held.
  always @(negedge clk) begin
    if (a_out_valid && !prev_a) begin
      if (sb_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected_result q=0x%0h r=0x%0h", a_q, a_r);
      end else begin
        cur_a = sb_a.pop_front();
        check("a_latency", cyc - cur_a.acc + 1, cur_a.lat);
      end
    end
    if (a_out_valid) begin
      check("a_quotient", a_q, cur_a.q);
      check("a_remainder", a_r, cur_a.r);
      check("a_div_by_zero", a_dz, cur_a.dz);
      check("a_overflow", a_ov, cur_a.ov);
    end
    prev_a = a_out_valid;
  end

  // Monitor for the truncating instance.
  always @(negedge clk) begin
    if (b_out_valid && !prev_b) begin
      if (sb_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected_result q=0x%0h r=0x%0h", b_q, b_r);
      end else begin
        cur_b = sb_b.pop_front();
        check("b_latency", cyc - cur_b.acc + 1, cur_b.lat);
      end
    end
    if (b_out_valid) begin
      check("b_quotient", b_q, cur_b.q);
      check("b_remainder", b_r, cur_b.r);
      check("b_div_by_zero", b_dz, cur_b.dz);
      check("b_overflow", b_ov, cur_b.ov);
    end
    prev_b = b_out_valid;
  end

  task automatic wait_idle();
    int n = 0;
    while (!(a_in_ready && b_in_ready && !a_out_valid && !b_out_valid) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout waited=%0d cycles limit=50", n);
    end
  endtask

  task automatic op_issue(input logic [15:0] dvd, input logic [7:0] dvs,
                          input logic [7:0] qa, input logic [7:0] ra,
                          input logic dz, input logic ov, input int la,
                          input logic [7:0] qb, input logic [7:0] rb, input int lb);
    exp_t ea, eb;
    wait_idle();
    dividend = dvd;
    divisor  = dvs;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    ea = '{q: qa, r: ra, dz: dz, ov: ov, lat: la, acc: cyc};
    eb = '{q: qb, r: rb, dz: dz, ov: ov, lat: lb, acc: cyc};
    sb_a.push_back(ea);
    sb_b.push_back(eb);
  endtask

  task automatic op(input logic [15:0] dvd, input logic [7:0] dvs,
                    input logic [7:0] qa, input logic [7:0] ra,
                    input logic dz, input logic ov, input int la,
                    input logic [7:0] qb, input logic [7:0] rb, input int lb);
    op_issue(dvd, dvs, qa, ra, dz, ov, la, qb, rb, lb);
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout reached at cycle %0d", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready_a", a_in_ready, 0);
    check("rst_in_ready_b", b_in_ready, 0);
    rst = 1'b0;
    #1;
    check("reset_out_valid", a_out_valid, 0);
    check("reset_quotient", a_q, 0);
    check("reset_remainder", a_r, 0);
    check("reset_flags", {a_dz, a_ov}, 0);
    check("reset_in_ready", a_in_ready, 1);

    // Normal, max-quotient and saturating cases.
    op(16'd1000, 8'd7,   8'd142, 8'd6,   1'b0, 1'b0, 9, 8'd140, 8'd0,  7);
    op(16'hFE01, 8'd255, 8'd255, 8'd0,   1'b0, 1'b0, 9, 8'd252, 8'd0,  7);
    op(16'h0800, 8'd8,   8'hFF,  8'h00,  1'b0, 1'b1, 1, 8'hFF,  8'h00, 1);
    op(16'hFE00, 8'd255, 8'd254, 8'd254, 1'b0, 1'b0, 9, 8'd252, 8'd0,  7);
    op(16'hFFFF, 8'd255, 8'hFF,  8'hFF,  1'b0, 1'b1, 1, 8'hFF,  8'hFF, 1);

    // Divide by zero with the result held: no new accept possible.
    out_ready = 1'b0;
    op_issue(16'h1234, 8'd0, 8'hFF, 8'h34, 1'b1, 1'b0, 1, 8'hFF, 8'h34, 1);
    repeat (2) begin
      @(posedge clk);
      #1;
      check("dz_hold_in_ready_a", a_in_ready, 0);
      check("dz_hold_in_ready_b", b_in_ready, 0);
    end
    out_ready = 1'b1;
    wait_idle();

    // Backpressure after a normal result, with a competing in_valid that must be ignored.
    out_ready = 1'b0;
    op_issue(16'd1000, 8'd7, 8'd142, 8'd6, 1'b0, 1'b0, 9, 8'd140, 8'd0, 7);
    n = 0;
    while (!a_out_valid && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 30) begin
      checks++;
      errors++;
      $display("FAIL bp_wait_timeout waited=%0d limit=30", n);
    end
    dividend = 16'h1234;
    divisor  = 8'd0;
    in_valid = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      check("bp_in_ready_a", a_in_ready, 0);
      check("bp_in_ready_b", b_in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_idle();

    // Reset in the 4th BUSY cycle abandons the division.
    op_issue(16'd1000, 8'd7, 8'd142, 8'd6, 1'b0, 1'b0, 9, 8'd140, 8'd0, 7);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    void'(sb_a.pop_back());
    void'(sb_b.pop_back());
    #1;
    check("abort_in_ready_a", a_in_ready, 1);
    check("abort_in_ready_b", b_in_ready, 1);
    repeat (12) begin
      @(posedge clk);
      #1;
      check("abort_no_out_valid", {a_out_valid, b_out_valid}, 0);
    end

    op(16'd200,   8'd3, 8'd66,  8'd2, 1'b0, 1'b0, 9,        8'd64,  8'd0, 7);
    op(16'h0055,  8'd1, 8'h55,  8'd0, 1'b0, 1'b0, ET_LAT_A, ET55_B, 8'd0, ET_LAT_B);
    op(16'h0000,  8'd5, 8'h00,  8'd0, 1'b0, 1'b0, ET_LAT_A, 8'h00,  8'd0, ET_LAT_B);

    repeat (2) @(posedge clk);
    #1;
    check("sb_a_drained", sb_a.size(), 0);
    check("sb_b_drained", sb_b.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
